// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the core's single-cycle data port to a valid/ready data bus.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of truncating them.
module lsu_mem_bridge #(
    parameter int BUS_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wen,
    input  logic [2:0]        req_memop,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [BUS_AW-1:0] bus_addr,
    output logic              bus_wen,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic [2:0]  memop_r;
    logic [1:0]  off_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        legal;
    logic        acc_err;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        legal = 1'b0;
        case (req_memop)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_wen;
            default:                legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_memop[1:0])
            2'b01:   acc_err = !legal || req_addr[0];
            2'b10:   acc_err = !legal || (req_addr[1:0] != 2'b00);
            default: acc_err = !legal;
        endcase
`else
        acc_err = !legal;
`endif
        // Without the trap, H/W offsets round down to the natural boundary.
        case (req_memop[1:0])
            2'b00: begin
                off       = req_addr[1:0];
                strb      = 4'b0001 << off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                off       = {req_addr[1], 1'b0};
                strb      = 4'b0011 << off;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                off       = 2'b00;
                strb      = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = bus_rdata >> {off_r, 3'b000};
        case (memop_r)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b101:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            memop_r     <= '0;
            off_r       <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            bus_addr    <= '0;
            bus_wen     <= 1'b0;
            bus_wstrb   <= '0;
            bus_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (acc_err) begin
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= '0;
                            state       <= RESP;
                        end else begin
                            rsp_err_r <= 1'b0;
                            memop_r   <= req_memop;
                            off_r     <= off;
                            bus_addr  <= BUS_AW'({req_addr[31:2], 2'b00});
                            bus_wen   <= req_wen;
                            bus_wstrb <= req_wen ? strb : 4'b0000;
                            bus_wdata <= wdata_rep;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        rsp_rdata_r <= bus_wen ? '0 : load_data;
                        state       <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus_req_valid = (state == REQ);
    assign rsp_valid     = (state == RESP);
    assign rsp_err       = rsp_valid && rsp_err_r;
    assign rsp_rdata     = rsp_valid ? rsp_rdata_r : '0;

endmodule
